lap_timer_ctrl: RTL and testbench
=================================

# lap_timer_ctrl

Lap/split timer controller built on the shared `time_t` (20-bit) time type. It sequences a free-running tick counter from start/lap/stop/clear commands and computes each lap interval modulo 2^20. It tracks the best (shortest) lap and streams each completed lap as decimal digits to the display path through a valid/ready handshake. It sits between the debounced button pulses and the seven-segment/character display driver.

## Interface
- `TICK_DIV`, default 50000: clock cycles per time unit; legal range is ≥1.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `start_i` in 1: one-cycle start/resume pulse.
- `lap_i` in 1: one-cycle lap pulse.
- `stop_i` in 1: one-cycle stop pulse.
- `clear_i` in 1: one-cycle clear pulse.
- `running_o` out 1: high in RUN.
- `lap_valid_o` out 1: one-cycle pulse when `lap_time_o` updates.
- `lap_time_o` out `time_t`: last lap interval.
- `best_time_o` out `time_t`: shortest lap so far.
- `best_valid_o` out 1: `best_time_o` holds a recorded lap.
- `new_best_o` out 1: one-cycle pulse, coincident with `lap_valid_o`, when best updated.
- `digit_o` out 4: BCD digit.
- `digit_idx_o` out 3: digit position, 6 = most significant, 0 = least significant.
- `digit_valid_o` out 1: digit available.
- `digit_ready_i` in 1: display accepts digit.
- `busy_o` out 1: conversion or digit stream in progress, or pending.

## Operation
- FSM states are IDLE, RUN and HOLD. Reset and `clear_i` force IDLE and zero all registers and outputs.
- Tick counter:
  - The prescaler counts 0..TICK_DIV-1 only in RUN.
  - `now` increments, wrapping mod 2^20, in the cycle the prescaler is at TICK_DIV-1.
  - The prescaler holds its value in HOLD.
- `start_i`:
  - In IDLE: `now`, `mark` and the prescaler are set to 0, then → RUN.
  - In HOLD: → RUN, all values kept.
  - Ignored in RUN.
- `lap_i` in RUN, and `stop_i` in RUN, each record a lap:
  - delta = `now` − `mark`, mod 2^20, using the pre-increment `now` if a tick coincides.
  - `mark` ← `now`.
  - `lap_time_o` ← delta.
  - If `!best_valid_o` or delta ≤ `best_time_o` (ties count as new best): `best_time_o` ← delta, `best_valid_o` ← 1, and `new_best_o` pulses.
  - The delta is queued for conversion.
  - `stop_i` additionally moves the FSM → HOLD.
- `lap_i`/`stop_i` are ignored outside RUN.
- Simultaneous commands resolve by priority: clear > stop > lap > start.
- Conversion:
  - Sequential double-dabble: 20 shift/add-3 steps into 7 BCD digits (max 1048575).
  - Digits are then emitted most significant first, idx 6..0. Leading zeros are emitted.
  - A single pending register holds one queued delta. A lap arriving while busy overwrites the pending value (latest wins); an in-flight conversion or stream is never disturbed.
  - After the stream completes, a pending value starts conversion the next cycle.
- Handshake:
  - A digit transfers on `digit_valid_o && digit_ready_i`.
  - While valid is high and ready is low, `digit_o`/`digit_idx_o` are held stable.
  - Valid never drops without a transfer, except on clear or reset.

## Timing
- Reset values: every output is 0, and the FSM is in IDLE.
- A command sampled at edge N produces its register/output updates visible after edge N+1. `lap_valid_o`/`new_best_o` are high for that one cycle.
- Conversion, from an idle converter:
  - Loads at edge N+2.
  - Shifts on edges N+3..N+22.
  - First `digit_valid_o` is high after edge N+22.
- With ready held high, the 7 digits occupy 7 consecutive cycles, and `busy_o` falls after the last transfer edge if nothing is pending.
- `clear_i` mid-conversion or mid-stream: `digit_valid_o`, `busy_o` and the pending flag are all 0 after the next edge.

## Structure
- Shared in `time_pkg`:
  - the `lap_state_e` enum (IDLE/RUN/HOLD);
  - the constant `BCD_DIGITS = 7`;
  - `bcd_t` (7×4-bit);
  - the existing `time_delta`/`is_best_interval` helpers, used for the delta and compare.
- One sub-module, `bin2bcd_seq`, contains the double-dabble engine plus the digit serializer with the valid/ready port. `lap_timer_ctrl` holds the FSM, prescaler, best tracking and pending register.

## Test plan
- TICK_DIV=1, start, lap 100 cycles later:
  - `lap_time_o`=100, `best_time_o`=100, `new_best_o` pulse.
  - Digits are 0,0,0,0,1,0,0 with idx 6..0.
  - First valid 22 cycles after `lap_i`.
- Continue with laps of 50, then 80, then 50:
  - best updates to 50 with a pulse; the 80 lap gives no pulse.
  - The second 50 pulses `new_best_o` (tie), best stays 50.
- Wrap:
  - Lap at `now`=1048570, next lap 16 ticks later (`now`=10): `lap_time_o`=16.
  - Stream ends 0,0,0,0,0,1,6.
- Backpressure and overwrite:
  - Ready is low for 10 cycles during the stream: digit is stable and valid stays high.
  - Two laps during the stream (30, then 40): only 40 is streamed next.
- Simultaneous and clear:
  - `stop_i`+`lap_i` in the same cycle: one lap recorded and the FSM is in HOLD.
  - `start_i` resumes without zeroing `now`.
  - `clear_i` mid-stream: valid/busy/`best_valid_o` are 0 the next cycle, FSM is in IDLE.
  - Async `rst` asserted mid-cycle: outputs are 0 immediately.

Source files
------------

// File: rtl/time_pkg.sv
// Shared time type, lap FSM states and BCD helpers
// for the lap/split timer and its display path.
package time_pkg;

  localparam int TIME_W     = 20;
  localparam int BCD_DIGITS = 7;

  typedef logic [TIME_W-1:0] time_t;
  typedef logic [BCD_DIGITS-1:0][3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } lap_state_e;

  typedef enum logic [1:0] {
    CV_IDLE,
    CV_SHIFT,
    CV_OUT
  } cv_phase_e;

  function automatic time_t time_delta(
    input time_t now,
    input time_t mark
  );
    return now - mark;
  endfunction

  function automatic logic is_best_interval(
    input time_t d,
    input time_t best,
    input logic  have
  );
    return !have || (d <= best);
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter feeding a
// most-significant-first digit stream (valid/ready).
module bin2bcd_seq
  import time_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       start_i,
  input  time_t      bin_i,
  output logic       idle_o,
  output logic [3:0] digit_o,
  output logic [2:0] digit_idx_o,
  output logic       digit_valid_o,
  input  logic       digit_ready_i
);

  localparam int SW = BCD_DIGITS * 4 + TIME_W;

  cv_phase_e   phase_q;
  time_t       bin_q;
  bcd_t        bcd_q;
  logic [4:0]  cnt_q;
  logic [2:0]  idx_q;
  bcd_t        adj;
  logic [SW-1:0] sh;
  logic [BCD_DIGITS*4-1:0] flat;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_q[i] >= 4'd5) adj[i] = bcd_q[i] + 4'd3;
    end
    sh = {adj, bin_q} << 1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= CV_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else if (clr_i) begin
      phase_q <= CV_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      unique case (phase_q)
        CV_IDLE: begin
          if (start_i) begin
            bin_q   <= bin_i;
            bcd_q   <= '0;
            cnt_q   <= '0;
            phase_q <= CV_SHIFT;
          end
        end
        CV_SHIFT: begin
          bcd_q <= sh[SW-1:TIME_W];
          bin_q <= sh[TIME_W-1:0];
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'(TIME_W - 1)) begin
            phase_q <= CV_OUT;
            idx_q   <= 3'(BCD_DIGITS - 1);
          end
        end
        CV_OUT: begin
          if (digit_ready_i) begin
            if (idx_q == 3'd0) phase_q <= CV_IDLE;
            else idx_q <= idx_q - 3'd1;
          end
        end
        default: phase_q <= CV_IDLE;
      endcase
    end
  end

  // Digit and index come straight from held registers,
  // so they stay stable while the display stalls.
  assign flat          = bcd_q;
  assign digit_o       = 4'(flat >> {idx_q, 2'b00});
  assign digit_idx_o   = idx_q;
  assign digit_valid_o = (phase_q == CV_OUT);
  assign idle_o        = (phase_q == CV_IDLE);

endmodule

// File: rtl/lap_timer_ctrl.sv
// Lap/split timer: command FSM, tick prescaler,
// best-lap tracking and a one-deep display queue.
module lap_timer_ctrl
  import time_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       lap_i,
  input  logic       stop_i,
  input  logic       clear_i,
  output logic       running_o,
  output logic       lap_valid_o,
  output time_t      lap_time_o,
  output time_t      best_time_o,
  output logic       best_valid_o,
  output logic       new_best_o,
  output logic [3:0] digit_o,
  output logic [2:0] digit_idx_o,
  output logic       digit_valid_o,
  input  logic       digit_ready_i,
  output logic       busy_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  lap_state_e    state_q;
  logic          start_q, lap_q, stop_q;
  logic [PW-1:0] presc_q, presc_d;
  time_t         now_q, now_d, mark_q;
  time_t         lap_q_t, best_q, pend_val_q, delta;
  logic          lap_valid_q, new_best_q, best_valid_q;
  logic          pend_q, tick, rec, conv_idle, conv_start;

  always_comb begin
    tick       = (state_q == RUN) && (presc_q == PMAX);
    rec        = (state_q == RUN) && (stop_q || lap_q);
    delta      = time_delta(now_q, mark_q);
    conv_start = pend_q && conv_idle;
    presc_d    = presc_q;
    now_d      = now_q;
    if (state_q == RUN) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) now_d = now_q + 1'b1;
    end
    if (state_q == IDLE && start_q) begin
      presc_d = '0;
      now_d   = '0;
    end
  end

  // Commands are registered first, so every command
  // acts one edge after it is sampled. Clear acts at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      {start_q, lap_q, stop_q} <= '0;
      presc_q <= '0;
      now_q <= '0;
      mark_q <= '0;
      lap_q_t <= '0;
      best_q <= '0;
      best_valid_q <= 1'b0;
      lap_valid_q <= 1'b0;
      new_best_q <= 1'b0;
      pend_q <= 1'b0;
      pend_val_q <= '0;
    end else if (clear_i) begin
      state_q <= IDLE;
      {start_q, lap_q, stop_q} <= '0;
      presc_q <= '0;
      now_q <= '0;
      mark_q <= '0;
      lap_q_t <= '0;
      best_q <= '0;
      best_valid_q <= 1'b0;
      lap_valid_q <= 1'b0;
      new_best_q <= 1'b0;
      pend_q <= 1'b0;
      pend_val_q <= '0;
    end else begin
      start_q <= start_i;
      lap_q <= lap_i;
      stop_q <= stop_i;
      presc_q <= presc_d;
      now_q <= now_d;
      lap_valid_q <= 1'b0;
      new_best_q <= 1'b0;
      if (conv_start) pend_q <= 1'b0;
      if (rec) begin
        mark_q <= now_q;
        lap_q_t <= delta;
        lap_valid_q <= 1'b1;
        pend_q <= 1'b1;
        pend_val_q <= delta;
        if (is_best_interval(delta, best_q, best_valid_q)) begin
          best_q <= delta;
          best_valid_q <= 1'b1;
          new_best_q <= 1'b1;
        end
      end
      unique case (state_q)
        IDLE: begin
          if (start_q) begin
            mark_q <= '0;
            state_q <= RUN;
          end
        end
        RUN:  if (stop_q) state_q <= HOLD;
        HOLD: if (start_q) state_q <= RUN;
        default: state_q <= IDLE;
      endcase
    end
  end

  bin2bcd_seq u_conv (
    .clk           (clk),
    .rst           (rst),
    .clr_i         (clear_i),
    .start_i       (conv_start),
    .bin_i         (pend_val_q),
    .idle_o        (conv_idle),
    .digit_o       (digit_o),
    .digit_idx_o   (digit_idx_o),
    .digit_valid_o (digit_valid_o),
    .digit_ready_i (digit_ready_i)
  );

  assign running_o    = (state_q == RUN);
  assign lap_valid_o  = lap_valid_q;
  assign lap_time_o   = lap_q_t;
  assign best_time_o  = best_q;
  assign best_valid_o = best_valid_q;
  assign new_best_o   = new_best_q;
  assign busy_o       = pend_q || !conv_idle;

endmodule

// File: tb/tb_lap_timer_ctrl.sv
// Directed bench for lap_timer_ctrl with TICK_DIV=1,
// so one time unit per clock.
module tb_lap_timer_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        lap_i = 1'b0;
  logic        stop_i = 1'b0;
  logic        clear_i = 1'b0;
  logic        running_o;
  logic        lap_valid_o;
  logic [19:0] lap_time_o;
  logic [19:0] best_time_o;
  logic        best_valid_o;
  logic        new_best_o;
  logic [3:0]  digit_o;
  logic [2:0]  digit_idx_o;
  logic        digit_valid_o;
  logic        digit_ready_i = 1'b1;
  logic        busy_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic       stall_mon = 1'b0;
  logic       stable_bad = 1'b0;
  logic [3:0] held_d;
  logic [2:0] held_i;

  lap_timer_ctrl #(.TICK_DIV(1)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .lap_i         (lap_i),
    .stop_i        (stop_i),
    .clear_i       (clear_i),
    .running_o     (running_o),
    .lap_valid_o   (lap_valid_o),
    .lap_time_o    (lap_time_o),
    .best_time_o   (best_time_o),
    .best_valid_o  (best_valid_o),
    .new_best_o    (new_best_o),
    .digit_o       (digit_o),
    .digit_idx_o   (digit_idx_o),
    .digit_valid_o (digit_valid_o),
    .digit_ready_i (digit_ready_i),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (stall_mon && (!digit_valid_o || digit_o !== held_d
        || digit_idx_o !== held_i))
      stable_bad = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [27:0] to_bcd(input int unsigned v);
    logic [27:0] r;
    r = '0;
    for (int i = 0; i < 7; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic lap_at(input int t);
    while (cyc < t - 1) tick();
    lap_i = 1'b1;
    tick();
    lap_i = 1'b0;
  endtask

  task automatic lap_check(input int t, input int exp_lap,
                           input logic exp_nb, input int exp_best);
    lap_at(t);
    tick();
    check("lap_valid", 32'(lap_valid_o), 32'd1);
    check("lap_time", 32'(lap_time_o), 32'(exp_lap));
    check("new_best", 32'(new_best_o), 32'(exp_nb));
    check("best_time", 32'(best_time_o), 32'(exp_best));
  endtask

  task automatic get_stream(output logic [27:0] val, output int bad);
    int n;
    val = '0;
    bad = 0;
    for (int i = 6; i >= 0; i--) begin
      n = 0;
      while (!digit_valid_o && n < 200) begin
        tick();
        n++;
      end
      if (!digit_valid_o) bad++;
      if (digit_idx_o !== 3'(i)) bad++;
      val[4*i +: 4] = digit_o;
      tick();
    end
  endtask

  task automatic stream_check(input string tag, input int unsigned v);
    logic [27:0] got;
    int bad;
    get_stream(got, bad);
    check(tag, 32'(got), 32'(to_bcd(v)));
    check("stream_idx", 32'(bad), 32'd0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_o && n < 300) begin
      tick();
      n++;
    end
    check("busy_drain", 32'(busy_o), 32'd0);
  endtask

  initial begin
    int s, l1, l5, l7, lsim, a, n;
    logic [19:0] big;

    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_running", 32'(running_o), 32'd0);
    check("rst_lap_time", 32'(lap_time_o), 32'd0);
    check("rst_best", 32'(best_time_o), 32'd0);
    check("rst_best_valid", 32'(best_valid_o), 32'd0);
    check("rst_dvalid", 32'(digit_valid_o), 32'd0);
    check("rst_idx", 32'(digit_idx_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);

    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    s = cyc;
    check("run_latency", 32'(running_o), 32'd0);
    tick();
    check("running", 32'(running_o), 32'd1);

    l1 = s + 101;
    lap_check(l1, 100, 1'b1, 100);
    check("best_valid", 32'(best_valid_o), 32'd1);
    tick();
    check("lap_pulse_end", 32'(lap_valid_o), 32'd0);
    repeat (19) tick();
    check("dvalid_n21", 32'(digit_valid_o), 32'd0);
    tick();
    check("dvalid_n22", 32'(digit_valid_o), 32'd1);
    check("first_idx", 32'(digit_idx_o), 32'd6);
    stream_check("stream_100", 100);
    check("busy_fall", 32'(busy_o), 32'd0);

    lap_check(l1 + 50, 50, 1'b1, 50);
    lap_check(l1 + 130, 80, 1'b0, 50);
    lap_check(l1 + 180, 50, 1'b1, 50);

    l5 = l1 + 240;
    lap_check(l5, 60, 1'b0, 50);
    digit_ready_i = 1'b0;
    n = 0;
    while (!digit_valid_o && n < 100) begin
      tick();
      n++;
    end
    check("stall_valid", 32'(digit_valid_o), 32'd1);
    held_d = digit_o;
    held_i = digit_idx_o;
    stall_mon = 1'b1;
    lap_check(l5 + 30, 30, 1'b1, 30);
    l7 = l5 + 70;
    lap_check(l7, 40, 1'b0, 30);
    stall_mon = 1'b0;
    check("stall_stable", 32'(stable_bad), 32'd0);
    check("stall_idx", 32'(held_i), 32'd6);
    check("stall_digit", 32'(held_d), 32'd0);
    digit_ready_i = 1'b1;
    stream_check("stream_60", 60);
    stream_check("stream_latest", 40);
    wait_idle();

    lsim = l7 + 100;
    while (cyc < lsim - 1) tick();
    lap_i = 1'b1;
    stop_i = 1'b1;
    tick();
    lap_i = 1'b0;
    stop_i = 1'b0;
    tick();
    check("sim_lap_valid", 32'(lap_valid_o), 32'd1);
    check("sim_lap_time", 32'(lap_time_o), 32'd100);
    check("sim_new_best", 32'(new_best_o), 32'd0);
    check("sim_hold", 32'(running_o), 32'd0);
    tick();
    check("sim_one_lap", 32'(lap_valid_o), 32'd0);
    check("sim_best", 32'(best_time_o), 32'd30);
    wait_idle();

    big = 20'd1048570 - 20'(lsim - s - 1);
    force dut.now_q = 20'd1048570;
    tick();
    tick();
    release dut.now_q;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    a = cyc;
    lap_i = 1'b1;
    tick();
    lap_i = 1'b0;
    tick();
    check("resume_running", 32'(running_o), 32'd1);
    check("resume_lap", 32'(lap_time_o), 32'(big));
    lap_check(a + 17, 16, 1'b1, 16);
    stream_check("stream_big", 32'(big));
    stream_check("stream_wrap", 16);
    wait_idle();

    lap_i = 1'b1;
    tick();
    lap_i = 1'b0;
    n = 0;
    while (!digit_valid_o && n < 100) begin
      tick();
      n++;
    end
    tick();
    lap_i = 1'b1;
    tick();
    lap_i = 1'b0;
    tick();
    check("pre_clear_busy", 32'(busy_o), 32'd1);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    tick();
    check("clr_dvalid", 32'(digit_valid_o), 32'd0);
    check("clr_busy", 32'(busy_o), 32'd0);
    check("clr_best_valid", 32'(best_valid_o), 32'd0);
    check("clr_idle", 32'(running_o), 32'd0);
    check("clr_lap_time", 32'(lap_time_o), 32'd0);
    repeat (30) tick();
    check("clr_no_leak", 32'(digit_valid_o), 32'd0);

    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (20) tick();
    lap_i = 1'b1;
    tick();
    lap_i = 1'b0;
    repeat (5) tick();
    check("pre_rst_run", 32'(running_o), 32'd1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_running", 32'(running_o), 32'd0);
    check("arst_lap_time", 32'(lap_time_o), 32'd0);
    check("arst_best_valid", 32'(best_valid_o), 32'd0);
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_dvalid", 32'(digit_valid_o), 32'd0);
    #10;
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
